// File: rtl/sico_play_stream_adapter_pkg.sv
// SiCoStreamPkg: shared stream constants and the saturating drop-counter helper.
package SiCoStreamPkg;
    localparam int DROP_CNT_W = 16;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] c);
        return (c == DROP_CNT_MAX) ? c : c + DROP_CNT_W'(1);
    endfunction
endpackage

// File: rtl/sico_sync_fifo.sv
// sico_sync_fifo: first-word-fall-through FIFO with wrap-bit pointers.
module sico_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [DATA_W-1:0]          data_i,
    output logic [DATA_W-1:0]          data_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sico_sync_fifo: DEPTH must be a power of two >= 2");
    end
    if (DATA_W < 1 || DATA_W > 1023) begin : g_bad_width
        $error("sico_sync_fifo: DATA_W must be 1..1023");
    end
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_q, rd_q;
    assign empty_o = wr_q == rd_q;
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign level_o = wr_q - rd_q;
    assign data_o  = mem[rd_q[AW-1:0]];
    always_ff @(posedge clk_i) begin
        if (push_i) mem[wr_q[AW-1:0]] <= data_i;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + PW'(1);
            if (pop_i)  rd_q <= rd_q + PW'(1);
        end
    end
endmodule

// File: rtl/sico_play_stream_adapter.sv
// sico_play_stream_adapter: buffers player words into a FIFO, counting words dropped while full.
module sico_play_stream_adapter
    import SiCoStreamPkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [DATA_W:0]         ply_i,
    output logic                    m_valid_o,
    output logic [DATA_W-1:0]       m_data_o,
    input  logic                    m_ready_i,
    input  logic                    clear_i,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic                    overflow_o,
    output logic [DROP_CNT_W-1:0]   drop_cnt_o
);
    logic empty, full, pop, push, drop;
    assign m_valid_o = ~empty;
    assign pop  = ~empty & m_ready_i;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign push = ply_i[DATA_W] & (~full | pop);
    assign drop = ply_i[DATA_W] & full & ~pop;
    sico_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (ply_i[DATA_W-1:0]),
        .data_o  (m_data_o),
        .empty_o (empty),
        .full_o  (full),
        .level_o (level_o)
    );
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (clear_i) begin
            overflow_o <= drop;
            drop_cnt_o <= drop ? DROP_CNT_W'(1) : '0;
        end else if (drop) begin
            overflow_o <= 1'b1;
            drop_cnt_o <= sat_inc(drop_cnt_o);
        end
    end
endmodule

// File: tb/tb_sico_play_stream_adapter.sv
// tb_sico_play_stream_adapter: table vectors plus a queue scoreboard for the stream adapter.
module tb_sico_play_stream_adapter;
    localparam int DW = 8;
    localparam int DP = 4;
    logic          clk_i = 0;
    logic          rst_ni = 0;
    logic [DW:0]   ply_i = '0;
    logic          m_valid_o, m_ready_i = 0, clear_i = 0, overflow_o;
    logic [DW-1:0] m_data_o;
    logic [2:0]    level_o;
    logic [15:0]   drop_cnt_o;
    int            checks = 0, failures = 0;
    logic [7:0]    q[$];
    int            mcnt = 0;
    logic          movf = 0;
    typedef struct {
        logic v; logic [7:0] d; logic rdy; logic clr;
        int lvl; logic [7:0] hd; logic ovf; int cnt;
    } vec_t;
    vec_t vecs[13];
    sico_play_stream_adapter #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .ply_i(ply_i), .m_valid_o(m_valid_o),
        .m_data_o(m_data_o), .m_ready_i(m_ready_i), .clear_i(clear_i),
        .level_o(level_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
    );
    always #5 clk_i = ~clk_i;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic state_chk();
        chk("level", 32'(level_o), 32'(q.size()));
        chk("valid", 32'(m_valid_o), 32'(q.size() != 0));
        chk("overflow", 32'(overflow_o), 32'(movf));
        chk("drop_cnt", 32'(drop_cnt_o), 32'(mcnt));
    endtask
    // Called at posedge+1; the model mirrors the cycle, then the edge is taken and state compared.
    task automatic cycle(input logic v, input logic [7:0] d, input logic rdy, input logic clr);
        logic mpop, mdrop;
        ply_i = {v, d};
        m_ready_i = rdy;
        clear_i = clr;
        mpop = (q.size() != 0) && rdy;
        mdrop = v && (q.size() == DP) && !mpop;
        if (mpop) begin
            chk("pop_data", 32'(m_data_o), 32'(q[0]));
            void'(q.pop_front());
        end
        if (v && !mdrop) q.push_back(d);
        if (clr) begin
            mcnt = mdrop ? 1 : 0;
            movf = mdrop;
        end else if (mdrop) begin
            movf = 1;
            if (mcnt < 65535) mcnt++;
        end
        @(posedge clk_i);
        #1;
        state_chk();
    endtask
    task automatic idle();
        ply_i = '0;
        m_ready_i = 0;
        clear_i = 0;
    endtask
    initial begin
        vecs[0]  = '{1, 8'h11, 0, 0, 1, 8'h11, 0, 0};
        vecs[1]  = '{0, 8'h00, 1, 0, 0, 8'h00, 0, 0};
        vecs[2]  = '{1, 8'h01, 0, 0, 1, 8'h01, 0, 0};
        vecs[3]  = '{1, 8'h02, 0, 0, 2, 8'h01, 0, 0};
        vecs[4]  = '{1, 8'h03, 0, 0, 3, 8'h01, 0, 0};
        vecs[5]  = '{1, 8'h04, 0, 0, 4, 8'h01, 0, 0};
        vecs[6]  = '{1, 8'h05, 0, 0, 4, 8'h01, 1, 1};
        vecs[7]  = '{1, 8'h20, 1, 0, 4, 8'h02, 1, 1};
        vecs[8]  = '{0, 8'h00, 1, 0, 3, 8'h03, 1, 1};
        vecs[9]  = '{0, 8'h00, 1, 0, 2, 8'h04, 1, 1};
        vecs[10] = '{0, 8'h00, 1, 0, 1, 8'h20, 1, 1};
        vecs[11] = '{0, 8'h00, 1, 0, 0, 8'h00, 1, 1};
        vecs[12] = '{0, 8'h00, 0, 1, 0, 8'h00, 0, 0};
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_level", 32'(level_o), 0);
        chk("rst_valid", 32'(m_valid_o), 0);
        chk("rst_overflow", 32'(overflow_o), 0);
        chk("rst_drop_cnt", 32'(drop_cnt_o), 0);
        rst_ni = 1;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 13; i++) begin
            cycle(vecs[i].v, vecs[i].d, vecs[i].rdy, vecs[i].clr);
            chk("vec_level", 32'(level_o), 32'(vecs[i].lvl));
            chk("vec_overflow", 32'(overflow_o), 32'(vecs[i].ovf));
            chk("vec_drop_cnt", 32'(drop_cnt_o), 32'(vecs[i].cnt));
            if (vecs[i].lvl != 0) chk("vec_head", 32'(m_data_o), 32'(vecs[i].hd));
        end
        for (int i = 0; i < DP; i++) cycle(1, 8'h30 + 8'(i), 0, 0);
        for (int i = 0; i < 70000; i++) cycle(1, 8'(i), 0, 0);
        chk("sat_drop_cnt", 32'(drop_cnt_o), 32'h0000_FFFF);
        chk("sat_overflow", 32'(overflow_o), 1);
        cycle(1, 8'hEE, 0, 1);
        chk("clr_drop_cnt", 32'(drop_cnt_o), 1);
        chk("clr_overflow", 32'(overflow_o), 1);
        for (int i = 0; i < DP; i++) cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 0, 1);
        for (int i = 0; i < 3; i++) cycle(1, 8'h40 + 8'(i), 0, 0);
        idle();
        #3 rst_ni = 0;
        #1;
        chk("midrst_valid", 32'(m_valid_o), 0);
        chk("midrst_level", 32'(level_o), 0);
        q.delete();
        mcnt = 0;
        movf = 0;
        @(posedge clk_i);
        #1 rst_ni = 1;
        state_chk();
        cycle(1, 8'hA5, 0, 0);
        chk("post_rst_head", 32'(m_data_o), 32'hA5);
        cycle(1, 8'hA6, 0, 0);
        for (int i = 0; i < 2; i++) cycle(0, 8'h00, 1, 0);
        for (int i = 0; i < 100; i++) cycle(1'($urandom), 8'($urandom), 1'($urandom), 0);
        for (int i = 0; i < DP; i++) cycle(0, 8'h00, 1, 0);
        chk("rand_drained", 32'(q.size()), 0);
        chk("rand_drop_cnt", 32'(drop_cnt_o), 32'(mcnt));
        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sico_play_stream_adapter.md
SICO_PLAY_STREAM_ADAPTER -- requirements
Module: sico_play_stream_adapter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload width in bits (1..1023).
REQ-002 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, >= 2; other values rejected at elaboration.
REQ-003 SHALL have port clk_i  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port ply_i  input  DATA_W+1  player word; bit DATA_W = valid, bits DATA_W-1:0 = data.
REQ-006 SHALL have port m_valid_o  output  1  head entry available.
REQ-007 SHALL have port m_data_o  output  DATA_W  head entry payload.
REQ-008 SHALL have port m_ready_i  input  1  consumer accepts head this cycle.
REQ-009 SHALL have port clear_i  input  1  synchronous clear of overflow_o and drop_cnt_o.
REQ-010 SHALL have port level_o  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-011 SHALL have port overflow_o  output  1  sticky: a valid player word was dropped.
REQ-012 SHALL have port drop_cnt_o  output  16  saturating count of dropped words.

Function
REQ-013 SHALL sample ply_i every cycle; a word with valid bit 1 is a push request, valid bit 0 is ignored (no backpressure toward the player exists).
REQ-014 SHALL implement first-word-fall-through: m_valid_o = (level != 0), m_data_o = oldest entry, combinationally from stored state only.
REQ-015 SHALL give push-to-output latency of exactly 1 cycle: word pushed at edge N is on m_valid_o/m_data_o after edge N.
REQ-016 SHALL pop on m_valid_o & m_ready_i; m_ready_i while empty has no effect.
REQ-017 SHALL never combinationally pass ply_i to m_data_o (no bypass when empty).
REQ-018 SHALL track states EMPTY (level 0), PARTIAL (0<level<DEPTH), FULL (level DEPTH); level +1 on push only, -1 on pop only, unchanged on push+pop.
REQ-019 SHALL accept a push while FULL only if a pop occurs the same cycle; level stays DEPTH.
REQ-020 SHALL otherwise drop a push while FULL: FIFO unchanged, overflow_o set, drop_cnt_o +1.
REQ-021 SHALL use read/write pointers of $clog2(DEPTH)+1 bits, wrapping modulo 2*DEPTH; full = MSBs differ and low bits equal.
REQ-022 SHALL saturate drop_cnt_o at 16'hFFFF; further drops leave it unchanged, overflow_o stays 1.
REQ-023 SHALL, on clear_i without a drop, set overflow_o=0 and drop_cnt_o=0 next cycle; FIFO contents unaffected.
REQ-024 SHALL, on clear_i coincident with a drop, yield overflow_o=1 and drop_cnt_o=1 (event not lost).
REQ-025 SHALL preserve strict FIFO order; no entry duplicated or reordered across pointer wrap.

Reset
REQ-026 SHALL, while rst_ni=0, asynchronously force pointers 0, level_o=0, m_valid_o=0, overflow_o=0, drop_cnt_o=0; m_data_o don't-care.
REQ-027 SHALL, on reset asserted mid-operation, discard all buffered entries; first push after deassertion appears one cycle later.
REQ-028 SHALL ignore ply_i, m_ready_i and clear_i during reset; storage array needs no reset.

Structure
REQ-029 SHALL take DROP_CNT_W (16) and DROP_CNT_MAX from shared package SiCoStreamPkg.
REQ-030 SHALL place storage, pointers and full/empty logic in sub-module sico_sync_fifo (params DATA_W, DEPTH); adapter holds decode, drop logic, counters.

Verification
REQ-031 SHALL cover: DATA_W=8, push 0x11 with m_ready_i=0 -> next cycle m_valid_o=1, m_data_o=0x11, level_o=1.
REQ-032 SHALL cover: DEPTH=4, 5 consecutive valid words 0x01..0x05, m_ready_i=0 -> level_o=4, 0x05 dropped, overflow_o=1, drop_cnt_o=1; drain yields 0x01..0x04.
REQ-033 SHALL cover: FULL, push 0x20 with m_ready_i=1 same cycle -> no drop, level_o stays 4, 0x20 last in drain order.
REQ-034 SHALL cover: 70000 drops while FULL -> drop_cnt_o=0xFFFF; clear_i coincident with drop -> drop_cnt_o=1, overflow_o=1.
REQ-035 SHALL cover: 3 entries held, rst_ni pulsed low mid-cycle -> m_valid_o=0 immediately, level_o=0; pushes 0xA5,0xA6 after release drain in order.
REQ-036 SHALL cover: 100 random words, random m_ready_i, DEPTH=4 -> output sequence equals accepted inputs in order, drop_cnt_o equals scoreboard drops.
